// File: rtl/megaram_mem_pkg.sv
// Shared types and constants for the MegaRAM memory-side port engine.
package megaram_mem_pkg;

  typedef enum logic [1:0] {
    MM_IDLE = 2'd0,
    MM_REQ  = 2'd1,
    MM_HOLD = 2'd2
  } mm_state_e;

  // Value presented on the slot bus when no memory data is available.
  localparam logic [7:0] MM_FLOAT_DATA = 8'hFF;

  // Timeout counter is sized for the largest supported TIMEOUT (1023).
  localparam int MM_TIMEOUT_MAX = 1023;
  localparam int MM_TMO_W       = $clog2(MM_TIMEOUT_MAX + 1);

  typedef logic [MM_TMO_W-1:0] mm_tmo_t;

  // True when the Z80 has released every strobe of the slot cycle.
  function automatic logic mm_bus_released(input logic merq_n,
                                           input logic rd_n,
                                           input logic wr_n);
    return merq_n & rd_n & wr_n;
  endfunction

endpackage

// File: rtl/megaram_mem_port_if.sv
// Request/acknowledge link between the MegaRAM port and the memory arbiter.
interface megaram_mem_port_if #(
  parameter int ADDR_W = 23
);
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_adr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  // The port engine issues requests.
  modport master (
    output mem_req, mem_wr, mem_adr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  // The memory controller answers them.
  modport slave (
    input  mem_req, mem_wr, mem_adr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/megaram_mem_watchdog.sv
// Loadable down-counter: expire pulses on the enabled cycle that would take
// the count from 1 to 0, i.e. after load_val enabled cycles.
module megaram_mem_watchdog
  import megaram_mem_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    clr,
  input  logic    load,
  input  mm_tmo_t load_val,
  input  logic    en,
  output logic    expire
);

  mm_tmo_t cnt_q, cnt_d;

  // Next count: clear beats load beats decrement; parks at zero.
  always_comb begin
    // NOTE: cnt_d gets a default first so every path assigns it and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire = en && !clr && !load && (cnt_q == mm_tmo_t'(1));

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/megaram_mem_port.sv
// MegaRAM/SCC memory-side engine: turns one Z80 slot cycle into one
// req/ack transaction, holds the CPU with WAIT and returns read data.
module megaram_mem_port
  import megaram_mem_pkg::*;
#(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cart_ena,
  input  logic              merq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              ram_ena,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        cdin,
  output logic [7:0]        cdout,
  output logic              cdout_oe,
  output logic              wait_n,
  output logic              err_timeout,
  megaram_mem_port_if.master mem
);

  mm_state_e         state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        cdout_q, cdout_d;
  logic              cdout_oe_q, cdout_oe_d;
  logic              wait_n_q, wait_n_d;
  logic              err_timeout_q, err_timeout_d;

  logic wd_clr, wd_load, wd_en, wd_expire;
  logic start_rd, start_wr;

  // Exactly one strobe must qualify; a write only counts in RAM mode, so
  // bank-switch writes and double strobes never start a transaction.
  assign start_rd = cart_ena & ~merq_n & ~rd_n & wr_n;
  assign start_wr = cart_ena & ~merq_n & ~wr_n & rd_n & ram_ena;

  megaram_mem_watchdog u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clr      (wd_clr),
    .load     (wd_load),
    .load_val (mm_tmo_t'(TIMEOUT)),
    .en       (wd_en),
    .expire   (wd_expire)
  );

  // Next-state and next-output logic of the transaction FSM.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_wr_d      = mem_wr_q;
    mem_adr_d     = mem_adr_q;
    mem_wdata_d   = mem_wdata_q;
    cdout_d       = cdout_q;
    cdout_oe_d    = cdout_oe_q;
    wait_n_d      = wait_n_q;
    err_timeout_d = 1'b0;
    wd_clr        = 1'b0;
    wd_load       = 1'b0;
    wd_en         = 1'b0;

    unique case (state_q)
      MM_IDLE: begin
        if (start_rd || start_wr) begin
          state_d     = MM_REQ;
          mem_req_d   = 1'b1;
          mem_wr_d    = start_wr;
          mem_adr_d   = mem_addr;
          mem_wdata_d = cdin;
          wait_n_d    = 1'b0;
          cdout_oe_d  = 1'b0;
          wd_load     = 1'b1;
        end else begin
          wd_clr = 1'b1;
        end
      end

      MM_REQ: begin
        wd_en = 1'b1;
        // Ack is checked first so an ack on the expiry cycle still wins.
        if (mem.mem_ack) begin
          if (!mem_wr_q) begin
            cdout_d = mem.mem_rdata;
          end
          mem_req_d  = 1'b0;
          wait_n_d   = 1'b1;
          cdout_oe_d = !mem_wr_q;
          state_d    = MM_HOLD;
        end else if (wd_expire) begin
          mem_req_d     = 1'b0;
          cdout_d       = MM_FLOAT_DATA;
          err_timeout_d = 1'b1;
          wait_n_d      = 1'b1;
          cdout_oe_d    = !mem_wr_q;
          state_d       = MM_HOLD;
        end
      end

      MM_HOLD: begin
        wd_clr = 1'b1;
        // Wait for the whole bus cycle to end so a long strobe cannot retrigger.
        if (mm_bus_released(merq_n, rd_n, wr_n)) begin
          cdout_oe_d = 1'b0;
          state_d    = MM_IDLE;
        end
      end

      default: begin
        state_d    = MM_IDLE;
        mem_req_d  = 1'b0;
        wait_n_d   = 1'b1;
        cdout_oe_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= MM_IDLE;
      mem_req_q     <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_adr_q     <= '0;
      mem_wdata_q   <= '0;
      cdout_q       <= MM_FLOAT_DATA;
      cdout_oe_q    <= 1'b0;
      wait_n_q      <= 1'b1;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_wr_q      <= mem_wr_d;
      mem_adr_q     <= mem_adr_d;
      mem_wdata_q   <= mem_wdata_d;
      cdout_q       <= cdout_d;
      cdout_oe_q    <= cdout_oe_d;
      wait_n_q      <= wait_n_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_wr    = mem_wr_q;
  assign mem.mem_adr   = mem_adr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign cdout         = cdout_q;
  assign cdout_oe      = cdout_oe_q;
  assign wait_n        = wait_n_q;
  assign err_timeout   = err_timeout_q;

endmodule
